zcnt4_x1: RTL
=============

ZCNT4_X1 -- requirements
Module: zcnt4_x1

Interface
REQ-001 SHALL have port ck, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have ports i0, i1, i2, i3, inputs, 1 bit each: load value, i3 = MSB.
REQ-004 SHALL have port ld, input, 1 bit: synchronous load strobe.
REQ-005 SHALL have port en, input, 1 bit: count enable, used only in RUN.
REQ-006 SHALL have ports q0, q1, q2, q3, outputs, 1 bit each: counter value, q3 = MSB.
REQ-007 SHALL have port zq, output, 1 bit: zero flag, combinational NOR of q0..q3.
REQ-008 SHALL have port busy, output, 1 bit: high while the state is RUN.
REQ-009 SHALL have port tc, output, 1 bit: terminal-count pulse, high while the state is DONE.

Function
REQ-010 SHALL implement a 4-bit unsigned down-counter Q = {q3,q2,q1,q0} with states IDLE, RUN, DONE.
REQ-011 SHALL drive zq = ~(q3|q2|q1|q0) combinationally; no register on zq.
REQ-012 SHALL decode busy and tc from state only; both are glitch-free registered-state outputs.
REQ-013 SHALL, on ld=1 in any state: Q <= {i3..i0}; next state RUN if load value != 0, otherwise DONE.
REQ-014 SHALL give ld priority over en and over all other transitions.
REQ-015 SHALL, in RUN with ld=0, en=1 and Q>1: Q <= Q-1 and stay in RUN.
REQ-016 SHALL, in RUN with ld=0, en=1 and Q=1: Q <= 0 and go to DONE.
REQ-017 SHALL, in RUN with ld=0 and en=0: hold Q and state.
REQ-018 SHALL, in DONE with ld=0: hold Q=0, go to IDLE; tc is therefore high for exactly one cycle.
REQ-019 SHALL, in IDLE with ld=0: hold Q and state; en is ignored.
REQ-020 SHALL never wrap: Q never decrements below 0 and never goes from 0 to 15.
REQ-021 SHALL, on ld=1 in DONE: keep tc=1 for the current cycle, then take the next state per REQ-013.
REQ-022 SHALL give load-to-first-decrement latency of one cycle: a load at edge N allows the first decrement at edge N+1 if en=1.

Reset
REQ-023 SHALL, while rst=1, force immediately (no clock needed): Q=0, state IDLE, zq=1, busy=0, tc=0.
REQ-024 SHALL, when rst deasserts, hold IDLE until ld=1; rst in mid-RUN or DONE discards the count and any pending tc.

Verification
REQ-025 SHALL: ld=1, i=0011 for 1 cycle, then en=1 held -> Q=3,2,1,0 on successive edges; busy=1 for 3 cycles; tc=1 for exactly 1 cycle after Q reaches 0; then IDLE with zq=1.
REQ-026 SHALL: load 0101, run 2 enabled edges (Q=3), then pulse rst between edges -> Q=0, zq=1, busy=0, tc=0 asynchronously; with en=1 after release, Q stays 0.
REQ-027 SHALL: load 0010 with en pattern 1,0,0,1 -> Q=1,1,1,0; tc asserted only after the final decrement.
REQ-028 SHALL: in RUN at Q=1, apply ld=1, en=1, i=1100 together -> Q=12, state RUN, no tc pulse.
REQ-029 SHALL: ld=1 with i=0000 -> next edge state DONE, tc=1 for one cycle, busy=0 throughout, zq=1 throughout.
REQ-030 SHALL: in IDLE, hold en=1 for 5 cycles with ld=0 -> Q, busy, tc unchanged (0, 0, 0) and zq=1.

Source files
------------

// File: rtl/zcnt4_x1.sv
// zcnt4_x1: 4-bit loadable down-counter with IDLE/RUN/DONE control and a one-cycle terminal-count pulse.
module zcnt4_x1 (
    input  logic ck,
    input  logic rst,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic ld,
    input  logic en,
    output logic q0,
    output logic q1,
    output logic q2,
    output logic q3,
    output logic zq,
    output logic busy,
    output logic tc
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     r_state, w_next;
    logic [3:0] r_q, w_q_next, w_ld_val;
    assign w_ld_val = {i3, i2, i1, i0};
    always_ff @(posedge ck or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_q     <= 4'd0;
        end else begin
            r_state <= w_next;
            r_q     <= w_q_next;
        end
    // Load wins over everything; the r_q != 0 guard keeps the count from ever wrapping.
    always_comb begin
        w_next   = r_state;
        w_q_next = r_q;
        if (ld) begin
            w_q_next = w_ld_val;
            w_next   = (w_ld_val != 4'd0) ? RUN : DONE;
        end else if (r_state == RUN && en && r_q != 4'd0) begin
            w_q_next = r_q - 4'd1;
            w_next   = (r_q == 4'd1) ? DONE : RUN;
        end else if (r_state == DONE) begin
            w_q_next = 4'd0;
            w_next   = IDLE;
        end
    end
    always_comb begin
        busy = (r_state == RUN);
        tc   = (r_state == DONE);
        zq   = ~|r_q;
        {q3, q2, q1, q0} = r_q;
    end
endmodule
